shift_delay_line: RTL and testbench

Parametrised synchronous delay line: a chain of DEPTH registers, each WIDTH bits, that shifts data one stage per enabled rising clock edge. It generalises the fixed three-stage non-blocking register chain with configurable width and depth, shift enable, flush, runtime tap selection and fill tracking. It sits between a stimulus/sampling source and any consumer that needs a data stream delayed by a programmable number of cycles, such as a delay filter or an alignment stage.

---
 rtl/shift_delay_line_pkg.sv | 28 ++
 rtl/shift_delay_line_delay_stage.sv | 21 ++
 rtl/shift_delay_line.sv | 81 ++++++++
 tb/tb_shift_delay_line.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_delay_line_pkg.sv
// Shared sizing helpers and tap clamping for the shift_delay_line block.
// Widths are exposed as functions of DEPTH so each instance derives its own.
package shift_delay_line_pkg;

   localparam int DEFAULT_WIDTH = 1;
   localparam int DEFAULT_DEPTH = 3;

   // Never returns less than 1 so a depth of 1 still yields a legal vector.
   function automatic int safe_clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

   function automatic int tap_width(input int depth);
      return safe_clog2(depth);
   endfunction

   function automatic int fill_width(input int depth);
      return safe_clog2(depth + 1);
   endfunction

   function automatic int clamp_tap(input int sel, input int depth);
      return (sel >= depth) ? depth - 1 : sel;
   endfunction

endpackage

// File: rtl/shift_delay_line_delay_stage.sv
// One WIDTH-bit pipeline register with synchronous clear and load enable.
// Clear wins over load.
module delay_stage #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk) begin
      if (clr) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/shift_delay_line.sv
// Parametrised delay line with enable, flush, fill tracking and tap output.
// Runtime tap selection is built only when SHIFT_DELAY_LINE_TAP_SEL_EN is defined.
module shift_delay_line
   import shift_delay_line_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = DEFAULT_DEPTH,
   parameter int TW    = tap_width(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          flush,
   input  logic [WIDTH-1:0]              din,
   input  logic [TW-1:0]                 tap_sel,
   output logic [WIDTH-1:0]              dout,
   output logic [WIDTH-1:0]              dout_last,
   output logic                          tap_valid,
   output logic                          full,
   output logic [fill_width(DEPTH)-1:0]  fill_cnt
);

   localparam int FW = fill_width(DEPTH);

   logic             clr;
   logic [WIDTH-1:0] stage [DEPTH];

   assign clr = rst | flush;

   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         delay_stage #(.WIDTH(WIDTH)) u_stage (
            .clk  (clk),
            .clr  (clr),
            .load (en),
            .d    (din),
            .q    (stage[0])
         );
      end else begin : g_body
         delay_stage #(.WIDTH(WIDTH)) u_stage (
            .clk  (clk),
            .clr  (clr),
            .load (en),
            .d    (stage[i-1]),
            .q    (stage[i])
         );
      end
   end

   // Saturates at DEPTH so full stays asserted under continuous shifting.
   always_ff @(posedge clk) begin
      if (clr) begin
         fill_cnt <= '0;
      end else if (en && (fill_cnt != FW'(DEPTH))) begin
         fill_cnt <= fill_cnt + FW'(1);
      end
   end

   assign full      = (fill_cnt == FW'(DEPTH));
   assign dout_last = stage[DEPTH-1];

`ifdef SHIFT_DELAY_LINE_TAP_SEL_EN
   if (DEPTH == 1) begin : g_single
      logic unused_tap;
      assign unused_tap = ^tap_sel;
      assign dout       = stage[0];
      assign tap_valid  = full;
   end else begin : g_tap_mux
      logic [TW-1:0] tap_eff;
      assign tap_eff   = TW'(clamp_tap(int'(tap_sel), DEPTH));
      assign dout      = stage[tap_eff];
      assign tap_valid = (int'(fill_cnt) > int'(tap_eff));
   end
`else
   logic unused_tap;
   assign unused_tap = ^tap_sel;
   assign dout       = stage[DEPTH-1];
   assign tap_valid  = full;
`endif

endmodule

// File: tb/tb_shift_delay_line.sv
// Scoreboard bench for shift_delay_line: drivers queue expected results,
// a monitor compares one cycle of DUT output per queued entry.
module tb_shift_delay_line;

   typedef struct {
      int         id;
      logic [7:0] dout;
      logic [7:0] last;
      logic [3:0] fill;
      logic       full;
      logic       tv;
   } exp_t;

   logic clk;
   int   n_chk;
   int   n_fail;
   int   step_id;
   exp_t qa[$];
   exp_t qb[$];
   exp_t qc[$];
   exp_t ea, eb, ec;

   // dut_a: WIDTH=8 DEPTH=4
   logic       a_rst, a_en, a_flush;
   logic [7:0] a_din, a_dout, a_last;
   logic [1:0] a_tap;
   logic       a_tv, a_full;
   logic [2:0] a_fill;
   // dut_b: WIDTH=1 DEPTH=3
   logic       b_rst, b_en, b_flush;
   logic       b_din, b_dout, b_last;
   logic [1:0] b_tap;
   logic       b_tv, b_full;
   logic [1:0] b_fill;
   // dut_c: WIDTH=4 DEPTH=5, wide enough tap_sel to exercise clamping
   logic       c_rst, c_en, c_flush;
   logic [3:0] c_din, c_dout, c_last;
   logic [2:0] c_tap;
   logic       c_tv, c_full;
   logic [2:0] c_fill;

   logic mb [3];
   int   mfill;

   shift_delay_line #(.WIDTH(8), .DEPTH(4)) dut_a (
      .clk(clk), .rst(a_rst), .en(a_en), .flush(a_flush), .din(a_din), .tap_sel(a_tap),
      .dout(a_dout), .dout_last(a_last), .tap_valid(a_tv), .full(a_full), .fill_cnt(a_fill));

   shift_delay_line #(.WIDTH(1), .DEPTH(3)) dut_b (
      .clk(clk), .rst(b_rst), .en(b_en), .flush(b_flush), .din(b_din), .tap_sel(b_tap),
      .dout(b_dout), .dout_last(b_last), .tap_valid(b_tv), .full(b_full), .fill_cnt(b_fill));

   shift_delay_line #(.WIDTH(4), .DEPTH(5)) dut_c (
      .clk(clk), .rst(c_rst), .en(c_en), .flush(c_flush), .din(c_din), .tap_sel(c_tap),
      .dout(c_dout), .dout_last(c_last), .tap_valid(c_tv), .full(c_full), .fill_cnt(c_fill));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string nm, input int id, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", nm, id, act, req);
      end
   endtask

   // Without runtime taps, dout follows dout_last and tap_valid follows full.
   function automatic exp_t mk(input logic [7:0] xt, input logic [7:0] xl, input int xf,
                               input logic xfull, input logic xtv);
      exp_t x;
      x.id   = 0;
      x.last = xl;
      x.fill = 4'(xf);
      x.full = xfull;
`ifdef SHIFT_DELAY_LINE_TAP_SEL_EN
      x.dout = xt;
      x.tv   = xtv;
`else
      x.dout = xl;
      x.tv   = xfull;
`endif
      return x;
   endfunction

   task automatic drive_a(input logic r, e, f, input logic [7:0] d, input logic [1:0] t,
                          input logic [7:0] xt, xl, input int xf, input logic xfull, xtv);
      exp_t x;
      @(negedge clk);
      a_rst = r; a_en = e; a_flush = f; a_din = d;
`ifdef SHIFT_DELAY_LINE_TAP_SEL_EN
      a_tap = t;
`else
      a_tap = 2'd0;
`endif
      x = mk(xt, xl, xf, xfull, xtv);
      x.id = step_id++;
      qa.push_back(x);
   endtask

   task automatic drive_b(input logic r, e, f, d, input logic [1:0] t,
                          input logic xt, xl, input int xf, input logic xfull, xtv);
      exp_t x;
      @(negedge clk);
      b_rst = r; b_en = e; b_flush = f; b_din = d;
`ifdef SHIFT_DELAY_LINE_TAP_SEL_EN
      b_tap = t;
`else
      b_tap = 2'd0;
`endif
      x = mk({7'd0, xt}, {7'd0, xl}, xf, xfull, xtv);
      x.id = step_id++;
      qb.push_back(x);
   endtask

   task automatic drive_c(input logic r, e, f, input logic [3:0] d, input logic [2:0] t,
                          input logic [3:0] xt, xl, input int xf, input logic xfull, xtv);
      exp_t x;
      @(negedge clk);
      c_rst = r; c_en = e; c_flush = f; c_din = d;
`ifdef SHIFT_DELAY_LINE_TAP_SEL_EN
      c_tap = t;
`else
      c_tap = 3'd0;
`endif
      x = mk({4'd0, xt}, {4'd0, xl}, xf, xfull, xtv);
      x.id = step_id++;
      qc.push_back(x);
   endtask

   // Behavioural reference for the random run on dut_b.
   task automatic drive_b_rand(input logic e, f, d, input logic [1:0] t);
      exp_t x;
      int   eff;
      @(negedge clk);
      b_rst = 1'b0; b_en = e; b_flush = f; b_din = d;
      if (f) begin
         mb[0] = 1'b0; mb[1] = 1'b0; mb[2] = 1'b0;
         mfill = 0;
      end else if (e) begin
         mb[2] = mb[1]; mb[1] = mb[0]; mb[0] = d;
         if (mfill < 3) mfill++;
      end
`ifdef SHIFT_DELAY_LINE_TAP_SEL_EN
      b_tap = t;
      eff   = (int'(t) > 2) ? 2 : int'(t);
`else
      b_tap = 2'd0;
      eff   = 2;
`endif
      x.dout = {7'd0, mb[eff]};
      x.tv   = (mfill > eff);
      x.last = {7'd0, mb[2]};
      x.fill = 4'(mfill);
      x.full = (mfill == 3);
      x.id   = step_id++;
      qb.push_back(x);
   endtask

   always @(posedge clk) begin
      #1;
      if (qa.size() != 0) begin
         ea = qa.pop_front();
         chk("a_dout",      ea.id, 32'(a_dout), 32'(ea.dout));
         chk("a_dout_last", ea.id, 32'(a_last), 32'(ea.last));
         chk("a_fill_cnt",  ea.id, 32'(a_fill), 32'(ea.fill));
         chk("a_full",      ea.id, 32'(a_full), 32'(ea.full));
         chk("a_tap_valid", ea.id, 32'(a_tv),   32'(ea.tv));
      end
      if (qb.size() != 0) begin
         eb = qb.pop_front();
         chk("b_dout",      eb.id, 32'(b_dout), 32'(eb.dout));
         chk("b_dout_last", eb.id, 32'(b_last), 32'(eb.last));
         chk("b_fill_cnt",  eb.id, 32'(b_fill), 32'(eb.fill));
         chk("b_full",      eb.id, 32'(b_full), 32'(eb.full));
         chk("b_tap_valid", eb.id, 32'(b_tv),   32'(eb.tv));
      end
      if (qc.size() != 0) begin
         ec = qc.pop_front();
         chk("c_dout",      ec.id, 32'(c_dout), 32'(ec.dout));
         chk("c_dout_last", ec.id, 32'(c_last), 32'(ec.last));
         chk("c_fill_cnt",  ec.id, 32'(c_fill), 32'(ec.fill));
         chk("c_full",      ec.id, 32'(c_full), 32'(ec.full));
         chk("c_tap_valid", ec.id, 32'(c_tv),   32'(ec.tv));
      end
   end

   initial begin
      n_chk = 0; n_fail = 0; step_id = 0;
      a_rst = 1'b1; a_en = 1'b0; a_flush = 1'b0; a_din = '0; a_tap = '0;
      b_rst = 1'b1; b_en = 1'b0; b_flush = 1'b0; b_din = '0; b_tap = '0;
      c_rst = 1'b1; c_en = 1'b0; c_flush = 1'b0; c_din = '0; c_tap = '0;
      mfill = 0;
      mb[0] = 1'b0; mb[1] = 1'b0; mb[2] = 1'b0;

      // dut_a: fill, then tap 1 sees 0x33 and full after the fourth edge
      //      rst en fl din    tap  dout   last   fill full tv
      drive_a(1, 0, 0, 8'h00, 2'd0, 8'h00, 8'h00, 0, 0, 0);
      drive_a(0, 1, 0, 8'h11, 2'd1, 8'h00, 8'h00, 1, 0, 0);
      drive_a(0, 1, 0, 8'h22, 2'd1, 8'h11, 8'h00, 2, 0, 1);
      drive_a(0, 1, 0, 8'h33, 2'd1, 8'h22, 8'h00, 3, 0, 1);
      drive_a(0, 1, 0, 8'h44, 2'd1, 8'h33, 8'h11, 4, 1, 1);
      // reset mid-stream with en=1 drops everything
      drive_a(1, 1, 0, 8'h77, 2'd0, 8'h00, 8'h00, 0, 0, 0);
      // en toggles 1,0,1,0
      drive_a(0, 1, 0, 8'hAA, 2'd0, 8'hAA, 8'h00, 1, 0, 1);
      drive_a(0, 0, 0, 8'hBB, 2'd0, 8'hAA, 8'h00, 1, 0, 1);
      drive_a(0, 1, 0, 8'hCC, 2'd0, 8'hCC, 8'h00, 2, 0, 1);
      drive_a(0, 0, 0, 8'hDD, 2'd1, 8'hAA, 8'h00, 2, 0, 1);
      drive_a(0, 1, 0, 8'hEE, 2'd3, 8'h00, 8'h00, 3, 0, 0);
      drive_a(0, 1, 0, 8'h01, 2'd3, 8'hAA, 8'hAA, 4, 1, 1);
      // saturation
      drive_a(0, 1, 0, 8'h02, 2'd2, 8'hEE, 8'hCC, 4, 1, 1);
      // flush with en=1 discards din
      drive_a(0, 1, 1, 8'hFF, 2'd0, 8'h00, 8'h00, 0, 0, 0);
      drive_a(0, 1, 0, 8'h5A, 2'd0, 8'h5A, 8'h00, 1, 0, 1);
      drive_a(0, 1, 0, 8'h6B, 2'd1, 8'h5A, 8'h00, 2, 0, 1);
      drive_a(0, 0, 0, 8'h00, 2'd2, 8'h00, 8'h00, 2, 0, 0);
      drive_a(0, 0, 0, 8'h00, 2'd3, 8'h00, 8'h00, 2, 0, 0);
      drive_a(0, 0, 1, 8'h00, 2'd0, 8'h00, 8'h00, 0, 0, 0);
      @(negedge clk);
      a_en = 1'b0; a_flush = 1'b0;

      // dut_b: three zeros then a held one walks 100, 110, 111
      drive_b(1, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 0);
      drive_b(0, 1, 0, 1'b0, 2'd0, 1'b0, 1'b0, 1, 0, 1);
      drive_b(0, 1, 0, 1'b0, 2'd0, 1'b0, 1'b0, 2, 0, 1);
      drive_b(0, 1, 0, 1'b0, 2'd0, 1'b0, 1'b0, 3, 1, 1);
      drive_b(0, 1, 0, 1'b1, 2'd1, 1'b0, 1'b0, 3, 1, 1);
      drive_b(0, 1, 0, 1'b1, 2'd1, 1'b1, 1'b0, 3, 1, 1);
      drive_b(0, 1, 0, 1'b1, 2'd2, 1'b1, 1'b1, 3, 1, 1);
      drive_b(1, 0, 0, 1'b0, 2'd0, 1'b0, 1'b0, 0, 0, 0);
      for (int i = 0; i < 48; i++) begin
         drive_b_rand(1'($urandom_range(0, 1)), ($urandom_range(0, 11) == 0),
                      1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
      end
      @(negedge clk);
      b_en = 1'b0; b_flush = 1'b0;

      // dut_c: out-of-range taps clamp to stage 4
      drive_c(1, 0, 0, 4'h0, 3'd0, 4'h0, 4'h0, 0, 0, 0);
      drive_c(0, 1, 0, 4'h1, 3'd0, 4'h1, 4'h0, 1, 0, 1);
      drive_c(0, 1, 0, 4'h2, 3'd7, 4'h0, 4'h0, 2, 0, 0);
      drive_c(0, 0, 0, 4'h9, 3'd5, 4'h0, 4'h0, 2, 0, 0);
      drive_c(0, 0, 0, 4'h9, 3'd1, 4'h1, 4'h0, 2, 0, 1);
      drive_c(0, 1, 0, 4'h3, 3'd6, 4'h0, 4'h0, 3, 0, 0);
      drive_c(0, 1, 0, 4'h4, 3'd4, 4'h0, 4'h0, 4, 0, 0);
      drive_c(0, 1, 0, 4'h5, 3'd7, 4'h1, 4'h1, 5, 1, 1);
      drive_c(0, 1, 0, 4'h6, 3'd3, 4'h3, 4'h2, 5, 1, 1);
      @(negedge clk);
      c_en = 1'b0;

      repeat (3) @(negedge clk);
      chk("queue_drain", step_id, 32'(qa.size() + qb.size() + qc.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
